denorm_shift_pipe: RTL
======================

Name: denorm_shift_pipe

Overview:
- Pipelined denormalizer: the inverse operation of the leading-zero-count/normalize path.
- Takes a normalized word plus its leading-zero count and shifts it back right to fixed-point position.
- Keeps the top OUT_WDT bits and optionally rounds half-to-even.
- Sits on the float/block-exponent to fixed-point return path of the CNN datapath. Valid/ready streaming on both sides.

Parameters:
- WORD_WDT, 64, width of normalized input word.
- CNT_WDT, $clog2(WORD_WDT)+1, width of shift-count input; must be able to represent WORD_WDT.
- OUT_WDT, 32, output width; must satisfy 1 <= OUT_WDT <= WORD_WDT.
- RND_EN, 1, 1 = round-nearest-even on discarded bits; 0 = truncate.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input this cycle.
- in_word  in  WORD_WDT  normalized word (MSB normally 1; not checked).
- in_lz_cnt  in  CNT_WDT  right-shift amount (leading-zero count to restore).
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- out_word  out  OUT_WDT  denormalized, rounded result.
- out_zero  out  1  out_word == 0.
- out_sat  out  1  rounding overflowed; out_word saturated to all ones.

Behaviour:
- Arithmetic:
  - sh = in_word >> in_lz_cnt (logical). If in_lz_cnt >= WORD_WDT, sh = 0.
  - Result base = sh[WORD_WDT-1 -: OUT_WDT].
  - guard = sh[WORD_WDT-OUT_WDT-1]; guard = 0 if OUT_WDT == WORD_WDT.
  - sticky = OR of sh[WORD_WDT-OUT_WDT-2:0] and every in_word bit shifted out below bit 0.
  - RND_EN=1: inc = guard & (sticky | base[0]). RND_EN=0: inc = 0.
  - If inc and base is all ones: out_word = all ones, out_sat = 1. Otherwise out_word = base + inc, out_sat = 0.
  - out_zero is computed from the final out_word.
- Pipeline: 3 registered stages.
  - S1: coarse shift by in_lz_cnt upper bits (multiples of 8), plus partial sticky.
  - S2: fine shift by low 3 bits, plus final guard/sticky.
  - S3: round, saturate, flags.
- Latency: 3 cycles from accepted input to out_valid when out_ready is held high. Throughput: 1 word/cycle.
- Handshake:
  - Single global advance enable: adv = !out_valid | out_ready.
  - in_ready = adv (combinational from out_ready and out_valid). A transfer occurs when in_valid & in_ready.
  - When adv = 0, all stages hold. Stage valids shift with adv; bubbles are not collapsed.
  - While out_valid = 1 and out_ready = 0: out_word, out_zero and out_sat stay stable.
  - out_valid never drops without a handshake.
- Reset:
  - All stage valids, out_valid, out_word, out_zero and out_sat go to 0 on the cycle after rst is sampled high.
  - Reset mid-operation discards all in-flight words.
  - in_ready is 1 on the first cycle after reset is released.
- Boundaries:
  - in_lz_cnt = 0: no shift; saturation possible.
  - in_lz_cnt = WORD_WDT-OUT_WDT: guard = original bit 0 of the discarded region alignment.
  - in_lz_cnt >= WORD_WDT (including values above WORD_WDT): out_word = 0, out_zero = 1, no rounding.
  - in_word = 0: out_word = 0, out_zero = 1, out_sat = 0.
  - Simultaneous out handshake and new input: accepted, no bubble inserted.

Test Plan:
All scenarios use WORD_WDT=16, OUT_WDT=8, RND_EN=1, out_ready=1 unless stated.
1. in_word=0xB400, in_lz_cnt=3 -> after 3 cycles: out_word=0x16 (tie, even kept), zero=0, sat=0. Then in_word=0xB500, cnt=3 -> 0x17.
2. in_word=0xFFFF, in_lz_cnt=0 -> out_word=0xFF, out_sat=1. With RND_EN=0 -> out_word=0xFF, out_sat=0.
3. in_word=0x8001, in_lz_cnt=8 -> sticky from shifted-out bit, out_word=0x01. in_word=0x8000, cnt=8 -> out_word=0x00, out_zero=1.
4. in_word=0x8000, in_lz_cnt=16 and cnt=31 -> out_word=0x00, out_zero=1, out_sat=0.
5. Back-to-back stream of 10 words with random out_ready throttling -> output order preserved, no drops or duplicates, outputs stable while out_ready=0, in_ready == (!out_valid | out_ready) every cycle.
6. Assert rst with 3 words in flight -> next cycle out_valid=0 and all outputs 0. The first word accepted after reset appears 3 cycles later with the correct value.

Source files
------------

// File: rtl/denorm_shift_pipe_if.sv
// Valid/ready stream bundle for the denormalizer: normalized word + shift in, fixed-point word + flags out.
interface denorm_shift_pipe_if #(
  parameter int WORD_WDT = 64,
  parameter int CNT_WDT  = $clog2(WORD_WDT) + 1,
  parameter int OUT_WDT  = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [WORD_WDT-1:0] in_word;
  logic [CNT_WDT-1:0]  in_lz_cnt;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_WDT-1:0]  out_word;
  logic                out_zero;
  logic                out_sat;

  modport master (
    output in_valid, in_word, in_lz_cnt, out_ready,
    input  in_ready, out_valid, out_word, out_zero, out_sat
  );

  modport slave (
    input  in_valid, in_word, in_lz_cnt, out_ready,
    output in_ready, out_valid, out_word, out_zero, out_sat
  );
endinterface

// File: rtl/denorm_shift_pipe.sv
// 3-stage denormalizer: coarse shift, fine shift + guard/sticky, round-half-even with saturation.
// One global advance enable stalls every stage together; bubbles travel with the data.
module denorm_shift_pipe #(
  parameter int WORD_WDT = 64,
  parameter int CNT_WDT  = $clog2(WORD_WDT) + 1,
  parameter int OUT_WDT  = 32,
  parameter int RND_EN   = 1
) (
  input logic clk,
  input logic rst,
  denorm_shift_pipe_if.slave bus
);
  localparam int STAGES = 3;
  localparam int R      = WORD_WDT - OUT_WDT;
  localparam logic [CNT_WDT:0]    W_L     = (CNT_WDT+1)'(WORD_WDT);
  // Selects the sh bits strictly below the guard position inside {sh, 2'b00}
  localparam logic [WORD_WDT+1:0] LO_MASK = {{(WORD_WDT+1-R){1'b0}}, {(R+1){1'b1}}};

  typedef struct packed {
    logic [WORD_WDT-1:0] word;
    logic                sticky;
    logic [2:0]          fine;
  } s1_t;

  typedef struct packed {
    logic [OUT_WDT-1:0] base;
    logic               guard;
    logic               sticky;
  } s2_t;

  logic               adv;
  logic [STAGES:1]    vld_pipe;
  s1_t                s1_d, s1_q;
  s2_t                s2_d, s2_q;
  logic [OUT_WDT-1:0] out_word_q;
  logic               out_zero_q, out_sat_q;

  assign adv = !vld_pipe[STAGES] | bus.out_ready;

  // S1: shift by whole bytes; bits dropped below bit 0 fold into sticky
  logic [CNT_WDT-1:0] coarse;
  logic [CNT_WDT:0]   keep;
  logic               big;

  always_comb begin
    coarse = {bus.in_lz_cnt[CNT_WDT-1:3], 3'b000};
    big    = ({1'b0, bus.in_lz_cnt} >= W_L);
    keep   = W_L - {1'b0, coarse};
    s1_d   = '0;
    s1_d.fine = bus.in_lz_cnt[2:0];
    if (!big) begin
      s1_d.word   = bus.in_word >> coarse;
      s1_d.sticky = |(bus.in_word << keep);
    end
  end

  // S2: residual 0..7 shift into an 8-bit tail, then split base/guard/sticky
  logic [WORD_WDT+7:0] fine_sh;
  logic [WORD_WDT+1:0] shp;

  always_comb begin
    fine_sh     = {s1_q.word, 8'h00} >> s1_q.fine;
    shp         = {fine_sh[WORD_WDT+7:8], 2'b00};
    s2_d        = '0;
    s2_d.base   = fine_sh[WORD_WDT+7 -: OUT_WDT];
    s2_d.guard  = shp[R+1];
    s2_d.sticky = s1_q.sticky | (|fine_sh[7:0]) | (|(shp & LO_MASK));
  end

  // S3: round half to even; a carry out of an all-ones base clamps instead of wrapping
  logic               inc, sat;
  logic [OUT_WDT-1:0] res;

  always_comb begin
    inc = (RND_EN != 0) && s2_q.guard && (s2_q.sticky || s2_q.base[0]);
    sat = inc && (&s2_q.base);
    res = sat ? '1 : s2_q.base + OUT_WDT'(inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      out_word_q <= '0;
      out_zero_q <= 1'b0;
      out_sat_q  <= 1'b0;
    end else if (adv) begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], bus.in_valid};
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      out_word_q <= res;
      out_zero_q <= (res == '0);
      out_sat_q  <= sat;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_word  = out_word_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_sat   = out_sat_q;
endmodule
